quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature encoder front end that converts one motor encoder's A/B pin pair into the 32-bit signed position word read by the HPS through a `quad_pio_N` input port. The block synchronises and glitch-filters both channels, decodes x4 quadrature into a wrapping up/down count, and flags illegal transitions. One instance exists per encoder (12 total). The synchronous clear is driven by the matching bit of the `quad_reset_pio` output word.

## Interface
- `CNT_W`, 32: position counter width; matches the PIO word.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per channel; minimum 2.
- `FILT_LEN`, 4: consecutive stable cycles required before a filtered channel changes; range 1–255.
- `clk_clk` input 1: system clock; all logic rises on this edge.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `enc_a` input 1: raw encoder channel A; asynchronous to the clock.
- `enc_b` input 1: raw encoder channel B; asynchronous to the clock.
- `clear` input 1: synchronous, active-high; zeroes the count and error state.
- `count` output CNT_W: signed position, two's complement.
- `dir` output 1: direction of the last valid step; 1 = forward, 0 = reverse.
- `step` output 1: one-cycle pulse in the cycle `count` changes.
- `err` output 1: sticky illegal-transition flag.
- `err_cnt` output 8: count of illegal transitions; saturates at 255.

## Operation
- **Synchroniser:** per channel, SYNC_STAGES flops give `a_s` and `b_s`.
- **Filter:** per channel, keep a filtered value `f` and a stability counter `c`.
  - If the synchronised input equals `f`: `c` ← 0.
  - Otherwise `c` increments. When `c` reaches FILT_LEN−1 with the input still different, `f` ← input and `c` ← 0.
  - Any pulse shorter than FILT_LEN cycles is discarded.
- **FSM states:** INIT and RUN.
  - INIT is entered on reset and lasts SYNC_STAGES+FILT_LEN cycles. In INIT, `f` and the previous state `prev` load directly from the synchronised inputs, no counting happens, and `step` stays 0.
  - After INIT the FSM moves to RUN and stays there until reset.
- **Decode in RUN:** compare `cur={f_a,f_b}` with `prev` each cycle, then `prev` ← `cur`.
  - Forward (+1) sequence: 00→10→11→01→00. Set `dir`=1 and pulse `step`.
  - Reverse (−1) is that sequence backwards. Set `dir`=0 and pulse `step`.
  - Unchanged: no action.
  - Both bits changed: illegal transition. `count` holds, `err` ← 1, `err_cnt` increments unless already 255.
- **Arithmetic:** `count` is modulo 2^CNT_W. 0x7FFFFFFF+1 gives 0x80000000; 0x00000000−1 gives 0xFFFFFFFF.
- **Clear:**
  - `count`, `err` and `err_cnt` go to 0; `dir` holds.
  - `prev` ← current `cur`, so the clear itself causes no step.
  - Clear overrides a step or error in the same cycle, and `step` is 0 in that cycle.
  - Clear during INIT is accepted and leaves the FSM in INIT.
- **Reset mid-operation:** all state returns immediately to reset values and INIT restarts.

## Timing
- Reset values: `count`=0, `dir`=0, `step`=0, `err`=0, `err_cnt`=0, FSM=INIT, all synchroniser and filter flops 0.
- Latency from an input transition sampled at edge k to the `count` update: SYNC_STAGES+FILT_LEN+1 edges, which is 7 with defaults. `step` is asserted in the same cycle.
- Maximum valid input rate: one transition per FILT_LEN+1 cycles per channel. Faster input is filtered out or reported as illegal.
- Clear takes effect on the edge after it is sampled high.
- All outputs are registered, so the PIO capture needs no extra stage.

## Structure
- Package `quad_pkg`:
  - `quad_state_t` enum {INIT, RUN}.
  - 2-bit `ab_t`.
  - Function `quad_delta(prev, cur)` returning −1, 0, +1, or an illegal indication.
  - Constant `ERR_CNT_MAX`=255.
- Sub-module `quad_filter` (SYNC_STAGES, FILT_LEN): synchroniser plus stability filter for one channel, instantiated twice. The decoder FSM, counter and error logic stay in `quad_decoder`.

## Test plan
1. Reset with A=B=1 held, then 20 idle cycles → `count` stays 0 and `step` never pulses, because INIT absorbs the startup state.
2. 100 forward cycles (400 edges, 10 clocks per edge) → `count`=400 and `dir`=1. Then 150 reverse edges → `count`=250 and `dir`=0.
3. From `count`=0, one reverse edge → `count`=0xFFFFFFFF. Force the count to 0x7FFFFFFF, then one forward edge → `count`=0x80000000.
4. A-channel glitch 3 cycles wide with FILT_LEN=4 → no change in `count`. A 4-cycle glitch → `count` changes by exactly ±1 at latency 7.
5. Drive 00→11 directly, 300 times → `count` holds, `err`=1, `err_cnt`=255 (saturated). Then `clear` → `err`=0 and `err_cnt`=0.
6. `clear` in the same cycle as a decoded forward step at `count`=42 → `count`=0 and `step`=0. The next forward edge gives `count`=1.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared types and the quadrature step decode for quad_decoder.
package quad_pkg;
  typedef enum logic {INIT, RUN} quad_state_t;
  typedef logic [1:0] ab_t;
  localparam logic [1:0] D_NONE = 2'd0;
  localparam logic [1:0] D_FWD  = 2'd1;
  localparam logic [1:0] D_ILL  = 2'd2;
  localparam logic [1:0] D_REV  = 2'd3;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;
  // {b,a} is a Gray code of the phase, so the binary phase difference gives the step
  function automatic logic [1:0] quad_delta(input ab_t prev, input ab_t cur);
    logic [1:0] p;
    logic [1:0] c;
    p = {prev[0], prev[0] ^ prev[1]};
    c = {cur[0], cur[0] ^ cur[1]};
    return c - p;
  endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: synchroniser plus stability filter for one encoder channel.
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  output logic sync,
  output logic filt
);
  logic [SYNC_STAGES-1:0] sr;
  logic [7:0] c;
  assign sync = sr[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      c <= '0;
      filt <= 1'b0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], raw};
      if (load || sync == filt || c == 8'(FILT_LEN - 1)) begin
        filt <= sync;
        c <= '0;
      end else c <= c + 8'd1;
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with filtering, wrapping count and illegal-transition tracking.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [7:0]       err_cnt
);
  quad_state_t state, state_nx;
  logic [8:0] init_cnt;
  logic a_s, b_s, f_a, f_b, init;
  ab_t prev, cur;
  logic [1:0] d;
  assign init = state == INIT;
  assign cur = {f_a, f_b};
  assign d = quad_delta(prev, cur);
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_a (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw(enc_a), .load(init), .sync(a_s), .filt(f_a)
  );
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_b (
    .clk(clk_clk), .rst_n(reset_reset_n), .raw(enc_b), .load(init), .sync(b_s), .filt(f_b)
  );
  always_comb state_nx = (init && init_cnt == 9'(SYNC_STAGES + FILT_LEN - 1)) ? RUN : state;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= INIT;
    else state <= state_nx;
  end
  // INIT tracks the synchronised pins so startup levels never decode as motion
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      init_cnt <= '0;
      prev <= '0;
      count <= '0;
      dir <= 1'b0;
      step <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      init_cnt <= init ? init_cnt + 9'd1 : init_cnt;
      prev <= init ? {a_s, b_s} : cur;
      step <= 1'b0;
      if (clear) begin
        count <= '0;
        err <= 1'b0;
        err_cnt <= '0;
      end else if (!init) begin
        if (d == D_FWD || d == D_REV) begin
          count <= (d == D_FWD) ? count + CNT_W'(1) : count - CNT_W'(1);
          dir <= d == D_FWD;
          step <= 1'b1;
        end else if (d == D_ILL) begin
          err <= 1'b1;
          if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed stimulus with a step scoreboard for quad_decoder.
module tb_quad_decoder;
  logic clk = 1'b0, rst_n = 1'b0, a = 1'b1, b = 1'b1, clr = 1'b0;
  logic [31:0] count;
  logic dir, step, err;
  logic [7:0] err_cnt;
  quad_decoder dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enc_a(a), .enc_b(b), .clear(clr),
    .count(count), .dir(dir), .step(step), .err(err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] c;
    logic d;
    int cy;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] m_cnt = '0;
  logic [1:0] cur = 2'b11;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (step) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step count=%h dir=%b cyc=%0d", count, dir, cyc);
        end else begin
          e = q.pop_front();
          if (count !== e.c || dir !== e.d || cyc != e.cy) begin
            errors++;
            $display("FAIL step got count=%h dir=%b cyc=%0d want count=%h dir=%b cyc=%0d",
                     count, dir, cyc, e.c, e.d, e.cy);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].cy) begin
        checks++;
        errors++;
        $display("FAIL missed_step cyc=%0d want count=%h at cyc=%0d", cyc, q[0].c, q[0].cy);
        e = q.pop_front();
      end
    end
  end
  function automatic logic [1:0] fwd(input logic [1:0] x);
    case (x)
      2'b00: fwd = 2'b10;
      2'b10: fwd = 2'b11;
      2'b11: fwd = 2'b01;
      default: fwd = 2'b00;
    endcase
  endfunction
  function automatic logic [1:0] rev(input logic [1:0] x);
    case (x)
      2'b10: rev = 2'b00;
      2'b11: rev = 2'b10;
      2'b01: rev = 2'b11;
      default: rev = 2'b01;
    endcase
  endfunction
  task automatic expect_step(input logic [1:0] f, input logic [1:0] t, input int cy);
    exp_t e;
    if (t == fwd(f)) begin
      m_cnt = m_cnt + 32'd1;
      e.d = 1'b1;
    end else begin
      m_cnt = m_cnt - 32'd1;
      e.d = 1'b0;
    end
    e.c = m_cnt;
    e.cy = cy;
    q.push_back(e);
  endtask
  task automatic go(input logic [1:0] n);
    if (n == fwd(cur) || n == rev(cur)) expect_step(cur, n, cyc + 7);
    cur = n;
    {a, b} = n;
    repeat (10) @(negedge clk);
  endtask
  task automatic pulse_a(input int w);
    logic [1:0] n;
    n = cur ^ 2'b10;
    if (w >= 4) begin
      expect_step(cur, n, cyc + 7);
      expect_step(n, cur, cyc + w + 7);
    end
    a = n[1];
    repeat (w) @(negedge clk);
    a = cur[1];
    repeat (14) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask
  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = '0;
    chk("clear_count", count, 32'h0);
    chk("clear_err", {31'b0, err}, 32'h0);
    chk("clear_err_cnt", {24'b0, err_cnt}, 32'h0);
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", count, 32'h0);
    chk("rst_dir", {31'b0, dir}, 32'h0);
    chk("rst_step", {31'b0, step}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("init_count", count, 32'h0);
    for (int i = 0; i < 400; i++) go(fwd(cur));
    chk("fwd_count", count, 32'd400);
    chk("fwd_dir", {31'b0, dir}, 32'h1);
    for (int i = 0; i < 150; i++) go(rev(cur));
    chk("rev_count", count, 32'd250);
    chk("rev_dir", {31'b0, dir}, 32'h0);
    do_clear();
    go(rev(cur));
    chk("wrap_down", count, 32'hFFFF_FFFF);
    force dut.count = 32'h7FFF_FFFF;
    @(negedge clk);
    release dut.count;
    m_cnt = 32'h7FFF_FFFF;
    @(negedge clk);
    chk("forced_count", count, 32'h7FFF_FFFF);
    go(fwd(cur));
    chk("wrap_up", count, 32'h8000_0000);
    pulse_a(3);
    chk("glitch3_count", count, 32'h8000_0000);
    pulse_a(4);
    chk("glitch4_count", count, 32'h8000_0000);
    for (int i = 0; i < 300; i++) go(~cur);
    chk("ill_count", count, 32'h8000_0000);
    chk("ill_err", {31'b0, err}, 32'h1);
    chk("ill_err_cnt", {24'b0, err_cnt}, 32'd255);
    do_clear();
    for (int i = 0; i < 42; i++) go(fwd(cur));
    chk("pre_clash_count", count, 32'd42);
    cur = fwd(cur);
    {a, b} = cur;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = '0;
    chk("clash_count", count, 32'h0);
    chk("clash_step", {31'b0, step}, 32'h0);
    repeat (5) @(negedge clk);
    go(fwd(cur));
    chk("post_clash_count", count, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 32'h0);
    chk("midrst_dir", {31'b0, dir}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_idle_count", count, 32'h0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_steps got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
